// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch and load/store ports, one access at a time.
// Optional build macro MEM_ARBITER_ROUND_ROBIN_EN: alternate grants when both ports request.
module mem_arbiter #(
    parameter int HOLD_CYCLES = 1,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_req_ready,
    output logic              i_rsp_valid,
    output logic [DATA_W-1:0] i_rsp_data,
    input  logic              d_req_valid,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    input  logic              d_req_we,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              mem_we
);

    // state  | meaning
    // IDLE   | waiting for a request; grants one port and latches its payload
    // ACCESS | memory bus driven for HOLD_CYCLES; sample/write on the last one
    // RESP   | one-cycle response pulse to the granted port
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(HOLD_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              sel_data_q, sel_data_d;
    logic [DATA_W-1:0] i_rsp_data_q, i_rsp_data_d;
    logic [DATA_W-1:0] d_rsp_data_q, d_rsp_data_d;
    logic              pick_data;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic last_data_q, last_data_d;

    // Pointer at 0 means fetch was granted last, so data wins the first tie.
    assign pick_data = d_req_valid && (!i_req_valid || !last_data_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_data_q <= 1'b0;
        end else begin
            last_data_q <= last_data_d;
        end
    end

    always_comb begin
        last_data_d = last_data_q;
        if (state_q == IDLE && (i_req_valid || d_req_valid)) begin
            last_data_d = pick_data;
        end
    end
`else
    assign pick_data = d_req_valid;
`endif

    assign i_rsp_data = i_rsp_data_q;
    assign d_rsp_data = d_rsp_data_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            sel_data_q   <= 1'b0;
            i_rsp_data_q <= '0;
            d_rsp_data_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            sel_data_q   <= sel_data_d;
            i_rsp_data_q <= i_rsp_data_d;
            d_rsp_data_q <= d_rsp_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        sel_data_d   = sel_data_q;
        i_rsp_data_d = i_rsp_data_q;
        d_rsp_data_d = d_rsp_data_q;
        i_req_ready  = 1'b0;
        d_req_ready  = 1'b0;
        i_rsp_valid  = 1'b0;
        d_rsp_valid  = 1'b0;
        mem_address  = '0;
        mem_data_in  = '0;
        mem_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_req_valid || d_req_valid) begin
                    d_req_ready = pick_data;
                    i_req_ready = !pick_data;
                    sel_data_d  = pick_data;
                    cnt_d       = CNT_LOAD;
                    state_d     = ACCESS;
                    if (pick_data) begin
                        addr_d  = {d_req_addr[ADDR_W-1:2], 2'b00};
                        wdata_d = d_req_wdata;
                        we_d    = d_req_we;
                    end else begin
                        addr_d  = {i_req_addr[ADDR_W-1:2], 2'b00};
                        wdata_d = '0;
                        we_d    = 1'b0;
                    end
                end
            end
            ACCESS: begin
                mem_address = addr_q;
                mem_data_in = wdata_q;
                if (cnt_q == 4'd0) begin
                    // Capture happens on the write edge, so a store returns the old word.
                    mem_we  = we_q;
                    state_d = RESP;
                    if (sel_data_q) begin
                        d_rsp_data_d = mem_data_out;
                    end else begin
                        i_rsp_data_d = mem_data_out;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                i_rsp_valid = !sel_data_q;
                d_rsp_valid = sel_data_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus random two-port traffic.
// Grant expectations follow MEM_ARBITER_ROUND_ROBIN_EN when it is defined.
module tb_mem_arbiter;

    localparam int HOLD    = 3;
    localparam int TIMEOUT = 300;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic        i_req_ready;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_data;
    logic        d_req_valid;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic        d_req_we;
    logic        d_req_ready;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_we;

    mem_arbiter #(.HOLD_CYCLES(HOLD), .ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .i_req_valid  (i_req_valid),
        .i_req_addr   (i_req_addr),
        .i_req_ready  (i_req_ready),
        .i_rsp_valid  (i_rsp_valid),
        .i_rsp_data   (i_rsp_data),
        .d_req_valid  (d_req_valid),
        .d_req_addr   (d_req_addr),
        .d_req_wdata  (d_req_wdata),
        .d_req_we     (d_req_we),
        .d_req_ready  (d_req_ready),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_data   (d_rsp_data),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_we       (mem_we)
    );

    always #5 clk = ~clk;

    // Memory instance the arbiter drives: combinational read, write on the clock edge.
    logic [31:0] mem [1024];
    always @(posedge clk) if (mem_we) mem[mem_address[11:2]] <= mem_data_in;
    assign mem_data_out = mem[mem_address[11:2]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endfunction

    // Reference model: memory contents as the architectural order of accesses implies.
    typedef struct {
        logic [31:0] data;
        int          due;
        int          word;
        logic        we;
    } ent_t;

    logic [31:0] ref_mem [1024];
    ent_t        iq[$];
    ent_t        dq[$];
    int          busy_end = -1;
    logic        acc_on = 1'b0;
    int          acc_start, acc_end;
    logic [31:0] acc_addr, acc_wdata;
    logic        acc_we;
    logic        last_i = 1'b1;
    logic [31:0] last_i_data = '0;
    logic [31:0] last_d_data = '0;

    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst_i_ready", i_req_ready, 0);
            chk("rst_d_ready", d_req_ready, 0);
            chk("rst_i_rsp_valid", i_rsp_valid, 0);
            chk("rst_d_rsp_valid", d_rsp_valid, 0);
            chk("rst_i_rsp_data", i_rsp_data, 0);
            chk("rst_d_rsp_data", d_rsp_data, 0);
            chk("rst_mem_address", mem_address, 0);
            chk("rst_mem_data_in", mem_data_in, 0);
            chk("rst_mem_we", mem_we, 0);
            // A dropped store never reached memory: undo it in the model.
            while (dq.size() > 0) begin
                ent_t e;
                e = dq.pop_front();
                if (e.we) ref_mem[e.word] = e.data;
            end
            iq.delete();
            busy_end    = -1;
            acc_on      = 1'b0;
            last_i      = 1'b1;
            last_i_data = '0;
            last_d_data = '0;
        end else begin
            logic idle, exp_d, exp_i;
            idle = (cyc > busy_end);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            exp_d = idle && d_req_valid && (!i_req_valid || last_i);
`else
            exp_d = idle && d_req_valid;
`endif
            exp_i = idle && i_req_valid && !exp_d;
            chk("d_req_ready", d_req_ready, exp_d);
            chk("i_req_ready", i_req_ready, exp_i);

            if (acc_on && cyc >= acc_start && cyc <= acc_end) begin
                chk("mem_address", mem_address, acc_addr);
                chk("mem_data_in", mem_data_in, acc_wdata);
                chk("mem_we", mem_we, acc_we && (cyc == acc_end));
            end else begin
                chk("bus_idle_address", mem_address, 0);
                chk("bus_idle_data_in", mem_data_in, 0);
                chk("bus_idle_we", mem_we, 0);
            end

            if (dq.size() > 0 && dq[0].due == cyc) begin
                chk("d_rsp_valid", d_rsp_valid, 1);
                chk("d_rsp_data", d_rsp_data, dq[0].data);
                last_d_data = dq[0].data;
                void'(dq.pop_front());
            end else begin
                chk("d_rsp_valid_quiet", d_rsp_valid, 0);
                chk("d_rsp_data_hold", d_rsp_data, last_d_data);
            end
            if (iq.size() > 0 && iq[0].due == cyc) begin
                chk("i_rsp_valid", i_rsp_valid, 1);
                chk("i_rsp_data", i_rsp_data, iq[0].data);
                last_i_data = iq[0].data;
                void'(iq.pop_front());
            end else begin
                chk("i_rsp_valid_quiet", i_rsp_valid, 0);
                chk("i_rsp_data_hold", i_rsp_data, last_i_data);
            end

            if (d_req_valid && d_req_ready) begin
                ent_t e;
                e.word = int'(d_req_addr[11:2]);
                e.data = ref_mem[e.word];
                e.due  = cyc + HOLD + 1;
                e.we   = d_req_we;
                dq.push_back(e);
                if (d_req_we) ref_mem[e.word] = d_req_wdata;
                acc_on    = 1'b1;
                acc_start = cyc + 1;
                acc_end   = cyc + HOLD;
                acc_addr  = {d_req_addr[31:2], 2'b00};
                acc_wdata = d_req_wdata;
                acc_we    = d_req_we;
                busy_end  = cyc + HOLD + 1;
                last_i    = 1'b0;
            end else if (i_req_valid && i_req_ready) begin
                ent_t e;
                e.word = int'(i_req_addr[11:2]);
                e.data = ref_mem[e.word];
                e.due  = cyc + HOLD + 1;
                e.we   = 1'b0;
                iq.push_back(e);
                acc_on    = 1'b1;
                acc_start = cyc + 1;
                acc_end   = cyc + HOLD;
                acc_addr  = {i_req_addr[31:2], 2'b00};
                acc_wdata = '0;
                acc_we    = 1'b0;
                busy_end  = cyc + HOLD + 1;
                last_i    = 1'b1;
            end
        end
    end

    task automatic d_issue(input logic [31:0] a, input logic we, input logic [31:0] wd);
        int n = 0;
        d_req_valid = 1'b1;
        d_req_addr  = a;
        d_req_we    = we;
        d_req_wdata = wd;
        forever begin
            @(negedge clk);
            if (d_req_ready) break;
            n++;
            if (n > TIMEOUT) begin
                checks++;
                errors++;
                $display("FAIL d_accept_timeout cyc=%0d actual=no_ready expected=ready", cyc);
                break;
            end
        end
        @(posedge clk);
        #1;
        d_req_valid = 1'b0;
        d_req_addr  = $urandom;
        d_req_we    = 1'($urandom);
        d_req_wdata = $urandom;
    endtask

    task automatic i_issue(input logic [31:0] a);
        int n = 0;
        i_req_valid = 1'b1;
        i_req_addr  = a;
        forever begin
            @(negedge clk);
            if (i_req_ready) break;
            n++;
            if (n > TIMEOUT) begin
                checks++;
                errors++;
                $display("FAIL i_accept_timeout cyc=%0d actual=no_ready expected=ready", cyc);
                break;
            end
        end
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        i_req_addr  = $urandom;
    endtask

    task automatic settle();
        repeat (HOLD + 3) @(posedge clk);
        #1;
    endtask

    task automatic gap();
        int n;
        n = $urandom_range(0, 3);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] old9;
        for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
        ref_mem[4] = 32'h0000_0013;
        ref_mem[8] = 32'h0000_0000;
        for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];

        resetn      = 1'b0;
        i_req_valid = 1'b0;
        i_req_addr  = '0;
        d_req_valid = 1'b0;
        d_req_addr  = '0;
        d_req_wdata = '0;
        d_req_we    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        i_issue(32'h0000_0010);
        settle();
        d_issue(32'h0000_0020, 1'b1, 32'hDEAD_BEEF);
        settle();
        d_issue(32'h0000_0020, 1'b0, 32'h1234_5678);
        settle();
        d_issue(32'h0000_0023, 1'b0, 32'h0);
        settle();

        fork
            begin
                for (int k = 0; k < 4; k++) d_issue(32'($urandom_range(0, 63)), 1'($urandom), $urandom);
            end
            i_issue(32'h0000_0044);
        join
        settle();

        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    gap();
                    d_issue(32'($urandom_range(0, 63)), 1'($urandom), $urandom);
                end
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    gap();
                    i_issue(32'($urandom_range(0, 63)));
                end
            end
        join
        settle();

        // Store to word 9 dropped by reset before its write cycle.
        old9 = ref_mem[9];
        d_issue(32'h0000_0024, 1'b1, 32'hCAFE_F00D);
        #1;
        resetn = 1'b0;
        #1;
        chk("midrst_mem_address", mem_address, 0);
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_mem_data_in", mem_data_in, 0);
        chk("midrst_d_rsp_valid", d_rsp_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        settle();
        settle();
        chk("midrst_word9_kept", mem[9], old9);
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
